// File: rtl/alu_seq.sv
// Execution sequencer for the 11-bit signed ALU: accepts one decoded instruction,
// drives the external ALU from registered operands, clamps and commits to acc/flag.
module alu_seq #(
  parameter int W    = 11,
  parameter int VMAX = 999
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic signed [W-1:0] in_arg1,
  input  logic signed [W-1:0] in_arg2,
  input  logic                flush,
  output logic [3:0]          alu_inst,
  output logic signed [W-1:0] alu_arg1,
  output logic signed [W-1:0] alu_arg2,
  output logic signed [W-1:0] alu_acc,
  input  logic signed [W-1:0] alu_out,
  output logic signed [W-1:0] acc,
  output logic [1:0]          flag,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic signed [W-1:0] P_MAX = W'(VMAX);
  localparam logic signed [W-1:0] P_MIN = W'(-VMAX);

  state_t              r_state, w_next;
  logic [3:0]          r_op;
  logic signed [W-1:0] r_arg1, r_arg2, r_acc;
  logic [1:0]          r_flag;
  logic                r_illegal;
  logic                w_legal, w_alu_op, w_commit, w_accept;

  function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x);
    if (x > P_MAX)      return P_MAX;
    else if (x < P_MIN) return P_MIN;
    else                return x;
  endfunction

  always_comb begin
    w_legal  = 1'b0;
    w_alu_op = 1'b0;
    case (r_op)
      4'd0, 4'd1, 4'd11, 4'd12, 4'd13: w_legal = 1'b1;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
        w_legal  = 1'b1;
        w_alu_op = 1'b1;
      end
      default: ;
    endcase
  end

  // flush in IDLE blocks acceptance; flush in EXEC suppresses the commit
  assign in_ready = (r_state == S_IDLE) && !flush;
  assign w_accept = in_ready && in_valid;
  assign w_commit = (r_state == S_EXEC) && !flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_arg1    <= '0;
      r_arg2    <= '0;
      r_acc     <= '0;
      r_flag    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= in_op;
        r_arg1 <= in_arg1;
        r_arg2 <= in_arg2;
      end
      if (w_commit) begin
        r_illegal <= !w_legal;
        case (r_op)
          4'd1:                         r_acc  <= clamp(r_arg1);
          4'd5, 4'd6, 4'd7, 4'd8, 4'd9: r_acc  <= clamp(alu_out);
          4'd11: r_flag <= (r_arg1 == r_arg2) ? 2'b01 : 2'b10;
          4'd12: r_flag <= (r_arg1 >  r_arg2) ? 2'b01 : 2'b10;
          4'd13: r_flag <= (r_arg1 <  r_arg2) ? 2'b01 : 2'b10;
          default: ;
        endcase
      end
    end
  end

  assign alu_inst = w_alu_op ? r_op : 4'd0;
  assign alu_arg1 = r_arg1;
  assign alu_arg2 = r_arg2;
  assign alu_acc  = r_acc;
  assign acc      = r_acc;
  assign flag     = r_flag;
  assign done     = (r_state == S_DONE);
  assign illegal  = done && r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural saturating ALU on the alu_* side, reference model
// fills a queue of expected commits, which are popped when done pulses.
module tb_alu_seq;
  localparam int W    = 11;
  localparam int VMAX = 999;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [3:0]          in_op = '0;
  logic signed [W-1:0] in_arg1 = '0;
  logic signed [W-1:0] in_arg2 = '0;
  logic                flush = 1'b0;
  logic [3:0]          alu_inst;
  logic signed [W-1:0] alu_arg1, alu_arg2, alu_acc, alu_out, acc;
  logic [1:0]          flag;
  logic                done, illegal;

  alu_seq #(.W(W), .VMAX(VMAX)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_arg1(in_arg1), .in_arg2(in_arg2), .flush(flush),
    .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_acc(alu_acc), .alu_out(alu_out), .acc(acc), .flag(flag),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [W-1:0] acc;
    logic [1:0]          flag;
    logic                ill;
  } exp_t;
  exp_t exp_q[$];

  int       vectors = 0;
  int       errors  = 0;
  int       m_acc   = 0;
  logic [1:0] m_flag = 2'b00;

  function automatic int sat_w(input int x);
    if (x > 1023)  return 1023;
    if (x < -1024) return -1024;
    return x;
  endfunction

  function automatic int clampv(input int x);
    if (x > VMAX)  return VMAX;
    if (x < -VMAX) return -VMAX;
    return x;
  endfunction

  // External ALU: acc op arg1, saturated to the W-bit range; anything else passes acc.
  function automatic int alu_model(input logic [3:0] inst, input int a, input int a1);
    case (inst)
      4'd5:    return sat_w(a + a1);
      4'd6:    return sat_w(a - a1);
      4'd7:    return sat_w(a * a1);
      4'd8:    return sat_w(-a);
      default: return a;
    endcase
  endfunction

  always_comb alu_out = W'(alu_model(alu_inst, int'(alu_acc), int'(alu_arg1)));

  task automatic model_push(input logic [3:0] op, input int a1, input int a2);
    exp_t e;
    e.ill = !(op inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12, 4'd13});
    case (op)
      4'd1:                         m_acc = clampv(a1);
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: m_acc = clampv(alu_model(op, m_acc, a1));
      4'd11: m_flag = (a1 == a2) ? 2'b01 : 2'b10;
      4'd12: m_flag = (a1 >  a2) ? 2'b01 : 2'b10;
      4'd13: m_flag = (a1 <  a2) ? 2'b01 : 2'b10;
      default: ;
    endcase
    e.acc  = W'(m_acc);
    e.flag = m_flag;
    exp_q.push_back(e);
  endtask

  // Offer an instruction until accepted (sampled on the falling edge), then drop in_valid.
  task automatic accept(input logic [3:0] op, input int a1, input int a2, output bit ok);
    ok = 1'b0;
    if (clk) @(negedge clk);
    in_op = op; in_arg1 = W'(a1); in_arg2 = W'(a2); in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int unsigned at);
    ok = 1'b0; at = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input int a1, input int a2,
                          output bit ok, output int unsigned at);
    bit acc_ok;
    accept(op, a1, a2, acc_ok);
    if (acc_ok) model_push(op, a1, a2);
    wait_done(ok, at);
    ok = ok && acc_ok;
  endtask

  task automatic test_reset();
    bit ok; int unsigned at; int pulses; exp_t e;
    repeat (3) @(negedge clk);
    vectors++;
    if ({acc, flag, done, illegal, alu_inst, in_ready} !== {11'sd0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: acc=%0d flag=%b done=%b ill=%b inst=%0d rdy=%b, want 0/00/0/0/0/1",
               acc, flag, done, illegal, alu_inst, in_ready);
    end
    rst_n = 1'b1;
    do_instr(4'd1, 5, 0, ok, at);
    e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
    vectors++;
    if (!ok || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
      errors++;
      $display("FAIL reset_pre_mov: ok=%b acc=%0d flag=%b ill=%b, want acc=%0d flag=%b ill=%b",
               ok, acc, flag, illegal, e.acc, e.flag, e.ill);
    end
    accept(4'd5, 3, 0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    m_acc = 0; m_flag = 2'b00;
    #2;
    vectors++;
    if (!ok || {acc, flag, done} !== {11'sd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_exec: ok=%b acc=%0d flag=%b done=%b, want 0/00/0", ok, acc, flag, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0 || in_ready !== 1'b1 || acc !== 11'sd0) begin
      errors++;
      $display("FAIL reset_no_retire: done_pulses=%0d rdy=%b acc=%0d, want 0/1/0", pulses, in_ready, acc);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ops[4] = '{4'd1, 4'd5, 4'd1, 4'd7};
    int         a1s[4] = '{5, 7, 3, -4};
    int unsigned t_prev, at;
    bit ok; exp_t e;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_instr(ops[i], a1s[i], 0, ok, at);
      e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
      vectors++;
      if (!ok || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
        errors++;
        $display("FAIL basic_%0d: ok=%b acc=%0d flag=%b ill=%b, want acc=%0d flag=%b ill=%b",
                 i, ok, acc, flag, illegal, e.acc, e.flag, e.ill);
      end
      if (i > 0) begin
        vectors++;
        if (at - t_prev != 3) begin
          errors++;
          $display("FAIL basic_period_%0d: %0d cycles between done, want 3", i, at - t_prev);
        end
      end
      t_prev = at;
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b one cycle after pulse, want 0", done);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] ops[5] = '{4'd1, 4'd5, 4'd1, 4'd6, 4'd1};
    int         a1s[5] = '{900, 200, -900, 500, 1010};
    int unsigned at; bit ok; exp_t e;
    for (int i = 0; i < 5; i++) begin
      do_instr(ops[i], a1s[i], 0, ok, at);
      e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
      vectors++;
      if (!ok || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
        errors++;
        $display("FAIL sat_%0d: ok=%b acc=%0d flag=%b, want acc=%0d flag=%b",
                 i, ok, acc, flag, e.acc, e.flag);
      end
    end
  endtask

  task automatic test_flags();
    logic [3:0] ops[5] = '{4'd12, 4'd13, 4'd11, 4'd5, 4'd11};
    int         a1s[5] = '{3, 3, 7, -1000, -5};
    int         a2s[5] = '{-2, -2, 7, 0, 6};
    int unsigned at; bit ok; exp_t e;
    for (int i = 0; i < 5; i++) begin
      do_instr(ops[i], a1s[i], a2s[i], ok, at);
      e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
      vectors++;
      if (!ok || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
        errors++;
        $display("FAIL flags_%0d: ok=%b acc=%0d flag=%b, want acc=%0d flag=%b",
                 i, ok, acc, flag, e.acc, e.flag);
      end
    end
  endtask

  task automatic test_flush();
    logic signed [W-1:0] acc0; int pulses; bit ok; int unsigned at; exp_t e;
    acc0 = acc;
    accept(4'd5, 4, 0, ok);
    @(negedge clk);
    vectors++;
    if (!ok || alu_inst !== 4'd5) begin
      errors++;
      $display("FAIL flush_exec_inst: ok=%b alu_inst=%0d, want 5", ok, alu_inst);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 0 || acc !== acc0) begin
      errors++;
      $display("FAIL flush_exec: done_pulses=%0d acc=%0d, want 0 and acc=%0d", pulses, acc, acc0);
    end
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_arg1 = 11'sd77;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_ready: in_ready=%b, want 0", in_ready);
    end
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || acc !== acc0) begin
      errors++;
      $display("FAIL flush_idle_drop: in_ready=%b acc=%0d, want 1 and %0d", in_ready, acc, acc0);
    end
    do_instr(4'd5, 4, 0, ok, at);
    e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
    vectors++;
    if (!ok || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
      errors++;
      $display("FAIL flush_after: ok=%b acc=%0d flag=%b, want acc=%0d flag=%b",
               ok, acc, flag, e.acc, e.flag);
    end
  endtask

  task automatic test_illegal();
    bit ok, ok2; int unsigned at; exp_t e;
    accept(4'd15, 123, 45, ok);
    if (ok) model_push(4'd15, 123, 45);
    @(negedge clk);
    vectors++;
    if (!ok || alu_inst !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL illegal_exec: ok=%b alu_inst=%0d done=%b, want 0/0", ok, alu_inst, done);
    end
    wait_done(ok2, at);
    e = exp_q.size() ? exp_q.pop_front() : '{acc: 'x, flag: 'x, ill: 'x};
    vectors++;
    if (!ok2 || {acc, flag, illegal} !== {e.acc, e.flag, e.ill}) begin
      errors++;
      $display("FAIL illegal_retire: ok=%b acc=%0d flag=%b ill=%b, want acc=%0d flag=%b ill=%b",
               ok2, acc, flag, illegal, e.acc, e.flag, e.ill);
    end
    @(negedge clk);
    vectors++;
    if ({done, illegal} !== 2'b00) begin
      errors++;
      $display("FAIL illegal_width: done=%b ill=%b, want 0/0", done, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_flags();
    test_flush();
    test_illegal();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected retirements left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
